// File: rtl/shiftreg_loader.sv
// shiftreg_loader: request/acknowledge sequencer that shifts the static and
// dynamic configuration words MSB-first onto one serial line, drives the
// chain selects, then pulses the latch strobes so both chains update together.
module shiftreg_loader #(
    parameter int SIZESRSTAT   = 88,
    parameter int SIZESRDYN    = 16,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START_FULL,
    input  logic                  START_DYN,
    input  logic [SIZESRSTAT-1:0] STAT_WORD,
    input  logic [SIZESRDYN-1:0]  DYN_WORD,
    output logic                  READY,
    output logic                  SDATA,
    output logic                  SHIFT_EN,
    output logic                  SELSTAT,
    output logic                  SELDYN,
    output logic                  LATCH_STAT,
    output logic                  LATCH_DYN,
    output logic                  DONE
);

    localparam int MAX_SD  = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int MAX_LEN = (MAX_SD > LATCH_CYCLES) ? MAX_SD : LATCH_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] STAT_LAST  = CW'(SIZESRSTAT - 1);
    localparam logic [CW-1:0] DYN_LAST   = CW'(SIZESRDYN - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_STAT,
        SHIFT_DYN,
        LATCH,
        FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full_q, full_d;
    logic [SIZESRSTAT-1:0]   stat_q, stat_d;
    logic [SIZESRDYN-1:0]    dyn_q, dyn_d;

    logic                    stat_bit;
    logic                    dyn_bit;

    // State, counter, mode flag and shadow words; reset aborts any sequence.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            stat_q  <= '0;
            dyn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            stat_q  <= stat_d;
            dyn_q   <= dyn_d;
        end
    end

    // Next-state: accept in IDLE, count cycles per phase, reload counter on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        full_d  = full_q;
        stat_d  = stat_q;
        dyn_d   = dyn_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (START_FULL || START_DYN) begin
                    stat_d  = STAT_WORD;
                    dyn_d   = DYN_WORD;
                    full_d  = START_FULL;
                    state_d = START_FULL ? SHIFT_STAT : SHIFT_DYN;
                end
            end
            SHIFT_STAT: begin
                if (cnt_q == STAT_LAST) begin
                    state_d = SHIFT_DYN;
                    cnt_d   = '0;
                end
            end
            SHIFT_DYN: begin
                if (cnt_q == DYN_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Serial bit select: the counter addresses shadow bit LEN-1-cnt (MSB first).
    always_comb begin
        stat_bit = 1'b0;
        dyn_bit  = 1'b0;
        for (int unsigned i = 0; i < SIZESRSTAT; i++) begin
            if (cnt_q == CW'(SIZESRSTAT - 1 - i)) stat_bit = stat_q[i];
        end
        for (int unsigned i = 0; i < SIZESRDYN; i++) begin
            if (cnt_q == CW'(SIZESRDYN - 1 - i)) dyn_bit = dyn_q[i];
        end
    end

    // Outputs decoded purely from flops, so no input reaches an output combinationally.
    always_comb begin
        READY      = 1'b0;
        SDATA      = 1'b0;
        SHIFT_EN   = 1'b0;
        SELSTAT    = 1'b0;
        SELDYN     = 1'b0;
        LATCH_STAT = 1'b0;
        LATCH_DYN  = 1'b0;
        DONE       = 1'b0;
        case (state_q)
            IDLE:       READY = 1'b1;
            SHIFT_STAT: begin
                SHIFT_EN = 1'b1;
                SELSTAT  = 1'b1;
                SDATA    = stat_bit;
            end
            SHIFT_DYN: begin
                SHIFT_EN = 1'b1;
                SELDYN   = 1'b1;
                SDATA    = dyn_bit;
            end
            LATCH: begin
                LATCH_DYN  = 1'b1;
                LATCH_STAT = full_q;
            end
            FINISH:     DONE = 1'b1;
            default:    READY = 1'b0;
        endcase
    end

endmodule

// File: doc/shiftreg_loader.md
# shiftreg_loader

Sequencer that loads the static (SIZESRSTAT-bit) and dynamic (SIZESRDYN-bit) configuration shift registers. It takes parallel configuration words, shifts them MSB-first onto one serial data line, and drives the SELSTAT/SELDYN selects. It then pulses the latch strobes so both registers update atomically. It sits between the configuration source and the shift-register chains, replacing free-running select generation with a request/acknowledge-driven load sequence.

## Interface
- SIZESRSTAT, 88, static shift register length (≥1)
- SIZESRDYN, 16, dynamic shift register length (≥1)
- LATCH_CYCLES, 2, width of latch strobe pulse in clock cycles (≥1)

- CLK  input  1  system clock, all logic on rising edge
- RST_N  input  1  asynchronous active-low reset
- START_FULL  input  1  request: load static then dynamic register
- START_DYN  input  1  request: load dynamic register only
- STAT_WORD  input  SIZESRSTAT  static configuration word, sampled on accept
- DYN_WORD  input  SIZESRDYN  dynamic configuration word, sampled on accept
- READY  output  1  idle, request will be accepted this cycle
- SDATA  output  1  serial data to shift-register chains
- SHIFT_EN  output  1  shift strobe, one bit per cycle while high
- SELSTAT  output  1  static chain selected
- SELDYN  output  1  dynamic chain selected
- LATCH_STAT  output  1  static latch strobe
- LATCH_DYN  output  1  dynamic latch strobe
- DONE  output  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, SHIFT_STAT, SHIFT_DYN, LATCH, FINISH.
- Reset values: state IDLE, READY=1, all other outputs 0, shadow registers and bit counter 0, mode flag 0.
- IDLE: READY=1. An accept happens on an edge where READY=1 and START_FULL or START_DYN is high. It copies STAT_WORD/DYN_WORD into shadow registers and records mode (full/dyn-only).
- Both starts high on the same edge: full load wins. The dyn request is consumed, not queued.
- Starts while READY=0: ignored, no queuing. Input words are not sampled.
- IDLE → SHIFT_STAT (full) or SHIFT_DYN (dyn-only).
- SHIFT_STAT: SHIFT_EN=1, SELSTAT=1. SDATA = static shadow bit SIZESRSTAT-1-n on the nth cycle (n from 0). Leaves after SIZESRSTAT cycles → SHIFT_DYN.
- SHIFT_DYN: SHIFT_EN=1, SELDYN=1. SDATA = dynamic shadow bit SIZESRDYN-1-n. Leaves after SIZESRDYN cycles → LATCH.
- LATCH: SHIFT_EN=0, SDATA=0, selects 0. LATCH_DYN=1 in both modes. LATCH_STAT=1 only in full mode. Lasts LATCH_CYCLES cycles → FINISH.
- FINISH: DONE=1 for one cycle, READY=0 → IDLE.
- SDATA=0 whenever SHIFT_EN=0. SELSTAT and SELDYN are never high together.
- Bit counter is sized to $clog2 of max(SIZESRSTAT, SIZESRDYN, LATCH_CYCLES)+1. It reloads to 0 on every state change. Shifting does not wrap.
- Shadow words are held constant during a sequence. Changing STAT_WORD/DYN_WORD mid-sequence has no effect.
- RST_N low at any time aborts immediately: outputs return to reset values asynchronously and no latch or DONE pulse is produced. After release, the first accept can occur on the first rising edge.

## Timing
- All outputs are registered (driven from state/counter flops). There is no combinational input-to-output path.
- Accept at edge k, full mode:
  - SHIFT_EN high cycles k+1 … k+SIZESRSTAT+SIZESRDYN (defaults: k+1…k+104)
  - SELSTAT high k+1…k+88, SELDYN high k+89…k+104
  - LATCH_STAT and LATCH_DYN high k+105…k+106
  - DONE k+107, READY high from k+108
- Accept at edge k, dyn-only mode:
  - SHIFT_EN and SELDYN high k+1…k+16
  - LATCH_DYN high k+17…k+18
  - DONE k+19, READY from k+20
- Full sequence length: SIZESRSTAT+SIZESRDYN+LATCH_CYCLES+1 cycles after accept. Dyn-only: SIZESRDYN+LATCH_CYCLES+1.
- Back-to-back: a start held high continuously is re-accepted on the first edge READY=1. The minimum gap between DONE pulses is sequence length +1.

## Test plan
- Reset: hold RST_N=0 → READY=1, all other outputs 0. Release, no start → outputs stay idle for 200 cycles.
- Full load with STAT_WORD=88'h80_0000_0000_0000_0000_0001, DYN_WORD=16'hA5C3:
  - SDATA=1 at k+1, 0 through k+87, 1 at k+88
  - SDATA over k+89…k+104 reproduces 1010010111000011
  - both latches high at k+105/106, DONE at k+107
- Dyn-only with DYN_WORD=16'hFFFF → SELSTAT never high, SDATA=1 for k+1…k+16, LATCH_STAT stays 0, DONE at k+19.
- START_FULL and START_DYN high on the same edge → full sequence (104 shift cycles). Pulse START_DYN at k+50 → ignored; exactly one DONE, at k+107.
- Change STAT_WORD to all-ones at k+10 of a full load with all-zeros captured → SDATA stays 0 throughout.
- Assert RST_N=0 at k+60 of a full load → outputs reset immediately, no LATCH or DONE pulse. A new START_DYN after release completes normally.
